// File: rtl/display_scanner_pkg.sv
// Shared constants for the 7-segment display scanner.
// Segment patterns are active-high and ordered {g,f,e,d,c,b,a}.
package display_scanner_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/display_scanner_if.sv
// Bus between the scan/load source and the display scanner, plus the pin outputs.
interface display_scanner_if
  import display_scanner_pkg::*;
#(
  parameter int N_DIGITS = 4
);
  logic                          i_tick;
  logic [DIGIT_W*N_DIGITS-1:0]   i_data;
  logic [N_DIGITS-1:0]           i_dp;
  logic                          i_load;
  logic                          i_blank_lz;
  logic                          o_load_ack;
  logic [N_DIGITS-1:0]           o_an;
  logic [6:0]                    o_seg;
  logic                          o_dp;

  modport master (
    output i_tick, i_data, i_dp, i_load, i_blank_lz,
    input  o_load_ack, o_an, o_seg, o_dp
  );

  modport slave (
    input  i_tick, i_data, i_dp, i_load, i_blank_lz,
    output o_load_ack, o_an, o_seg, o_dp
  );
endinterface

// File: rtl/display_scanner_hex_to_seg7.sv
// Combinational nibble to active-high 7-segment decoder.
module hex_to_seg7
  import display_scanner_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  output logic [6:0]         seg
);

  // Hex digit lookup
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 7-segment scanner with anti-ghosting blanking,
// frame-aligned double buffering and leading-zero suppression.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 4,
  parameter int ACTIVE_LOW   = 1
)(
  input  logic              i_clk,
  input  logic              i_reset,
  display_scanner_if.slave  bus
);

  localparam int                 IDX_W      = $clog2(N_DIGITS);
  localparam int                 DATA_W     = DIGIT_W * N_DIGITS;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_DIGITS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
  localparam logic [7:0]         BLANK_INIT = 8'(BLANK_CYCLES);
  localparam logic               POL        = (ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_ONE    = {{(N_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  logic [DATA_W-1:0]   pend_data_r;
  logic [N_DIGITS-1:0] pend_dp_r;
  logic                pend_v_r;
  logic [DATA_W-1:0]   act_data_r;
  logic [N_DIGITS-1:0] act_dp_r;
  logic [IDX_W-1:0]    idx_r;
  state_t              state_r;
  logic [7:0]          cnt_r;
  logic [N_DIGITS-1:0] an_r;
  logic [6:0]          seg_r;
  logic                dp_r;
  logic                ack_r;

  logic                boundary_s;
  logic [DATA_W-1:0]   act_data_s;
  logic [N_DIGITS-1:0] act_dp_s;
  logic [IDX_W-1:0]    idx_s;
  state_t              state_s;
  logic [7:0]          cnt_s;
  logic                zero_run_s;
  logic [N_DIGITS-1:0] lz_mask_s;
  logic [DIGIT_W-1:0]  digit_s;
  logic                dp_sel_s;
  logic [6:0]          seg_s;
  logic [N_DIGITS-1:0] an_s;

  // Next-state for scan index, blank timer and active buffer.
  // Outputs are registered from these next values so the anode tracks the FSM with no lag.
  always_comb begin
    boundary_s = bus.i_tick && (idx_r == LAST_IDX);
    act_data_s = act_data_r;
    act_dp_s   = act_dp_r;
    idx_s      = idx_r;
    state_s    = state_r;
    cnt_s      = cnt_r;

    if (boundary_s && pend_v_r) begin
      act_data_s = pend_data_r;
      act_dp_s   = pend_dp_r;
    end else begin
      act_data_s = act_data_r;
      act_dp_s   = act_dp_r;
    end

    if (bus.i_tick) begin
      idx_s   = (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + IDX_ONE;
      state_s = (BLANK_INIT == 8'd0) ? S_SHOW : S_BLANK;
      cnt_s   = BLANK_INIT;
    end else if (state_r == S_BLANK) begin
      // cnt holds the dark cycles still owed including the current one
      if (cnt_r <= 8'd1) begin
        state_s = S_SHOW;
        cnt_s   = 8'd0;
      end else begin
        state_s = S_BLANK;
        cnt_s   = cnt_r - 8'd1;
      end
    end else begin
      state_s = state_r;
      cnt_s   = cnt_r;
    end
  end

  // Leading-zero mask, scanned from the most significant digit down
  always_comb begin
    zero_run_s = 1'b1;
    lz_mask_s  = {N_DIGITS{1'b0}};
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s && (act_data_s[i*DIGIT_W +: DIGIT_W] == 4'h0);
      if (i != 0) begin
        lz_mask_s[i] = bus.i_blank_lz && zero_run_s && !act_dp_s[i];
      end else begin
        lz_mask_s[i] = 1'b0;
      end
    end
  end

  // Selected digit, decimal point and anode for the upcoming slot
  always_comb begin
    digit_s = 4'h0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_s == IDX_W'(i)) begin
        digit_s = act_data_s[i*DIGIT_W +: DIGIT_W];
      end else begin
        digit_s = digit_s;
      end
    end
    dp_sel_s = act_dp_s[idx_s];
    an_s     = AN_ONE << idx_s;
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (digit_s),
    .seg    (seg_s)
  );

  // Buffers, scan FSM and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend_data_r <= {DATA_W{1'b0}};
      pend_dp_r   <= {N_DIGITS{1'b0}};
      pend_v_r    <= 1'b0;
      act_data_r  <= {DATA_W{1'b0}};
      act_dp_r    <= {N_DIGITS{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      state_r     <= S_BLANK;
      cnt_r       <= BLANK_INIT;
      an_r        <= {N_DIGITS{POL}};
      seg_r       <= SEG_OFF ^ {7{POL}};
      dp_r        <= POL;
      ack_r       <= 1'b0;
    end else begin
      // A load on the boundary edge lands after the transfer, so it waits a frame
      if (bus.i_load) begin
        pend_data_r <= bus.i_data;
        pend_dp_r   <= bus.i_dp;
        pend_v_r    <= 1'b1;
      end else if (boundary_s) begin
        pend_v_r    <= 1'b0;
      end else begin
        pend_v_r    <= pend_v_r;
      end

      act_data_r <= act_data_s;
      act_dp_r   <= act_dp_s;
      idx_r      <= idx_s;
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      ack_r      <= boundary_s && pend_v_r;

      if ((state_s == S_SHOW) && !lz_mask_s[idx_s]) begin
        an_r  <= an_s ^ {N_DIGITS{POL}};
        seg_r <= seg_s ^ {7{POL}};
        dp_r  <= dp_sel_s ^ POL;
      end else begin
        an_r  <= {N_DIGITS{POL}};
        seg_r <= SEG_OFF ^ {7{POL}};
        dp_r  <= POL;
      end
    end
  end

  assign bus.o_an       = an_r;
  assign bus.o_seg      = seg_r;
  assign bus.o_dp       = dp_r;
  assign bus.o_load_ack = ack_r;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: a cycle-level reference model queues expected
// pin states, a separate monitor pops and compares after every clock edge.
module tb_display_scanner;

  localparam int N = 4;
  localparam int B = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ack;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_scanner_if #(.N_DIGITS(N)) bus ();

  display_scanner #(
    .N_DIGITS     (N),
    .BLANK_CYCLES (B),
    .ACTIVE_LOW   (1)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  // Active-low pin patterns for hex 0..F on {g,f,e,d,c,b,a}
  logic [6:0] seg_lo [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model state
  int          m_idx      = 0;
  int          m_dark     = B;
  logic [15:0] m_act      = 16'h0000;
  logic [3:0]  m_act_dp   = 4'h0;
  logic [15:0] m_pend     = 16'h0000;
  logic [3:0]  m_pend_dp  = 4'h0;
  bit          m_pend_v   = 1'b0;
  int          tick_cnt   = 0;
  bit          lz         = 1'b0;

  task automatic step(input bit r, input bit ld, input logic [15:0] d,
                      input logic [3:0] p, input bit extra);
    bit   tk;
    bit   ack;
    bit   blanked;
    int   dig;
    exp_t e;
    @(negedge clk);
    tk       = (tick_cnt == 9) || extra;
    tick_cnt = (tick_cnt == 9) ? 0 : tick_cnt + 1;
    rst            = r;
    bus.i_tick     = tk;
    bus.i_load     = ld;
    bus.i_data     = d;
    bus.i_dp       = p;
    bus.i_blank_lz = lz;
    ack = 1'b0;
    if (r) begin
      m_idx = 0; m_dark = B; m_act = 16'h0000; m_act_dp = 4'h0; m_pend_v = 1'b0;
    end else begin
      if (tk && m_idx == N - 1 && m_pend_v) begin
        m_act = m_pend; m_act_dp = m_pend_dp; m_pend_v = 1'b0; ack = 1'b1;
      end
      if (ld) begin
        m_pend = d; m_pend_dp = p; m_pend_v = 1'b1;
      end
      if (tk) begin
        m_idx  = (m_idx + 1) % N;
        m_dark = B;
      end else if (m_dark > 0) begin
        m_dark--;
      end
    end
    dig     = int'((m_act >> (4 * m_idx)) & 16'h000F);
    blanked = lz && (m_idx > 0) && ((m_act >> (4 * m_idx)) == 16'h0000) && !m_act_dp[m_idx];
    if (m_dark > 0 || blanked) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
    end else begin
      e.an  = ~(4'b0001 << m_idx);
      e.seg = seg_lo[dig];
      e.dp  = ~m_act_dp[m_idx];
    end
    e.ack = ack;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 1'b0);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p);
    step(1'b0, 1'b1, d, p, 1'b0);
  endtask

  // Monitor: compare the pins against the oldest queued expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({bus.o_an, bus.o_seg, bus.o_dp, bus.o_load_ack} !== e) begin
          fails++;
          $display("FAIL pins cycle %0d: got an=%b seg=%b dp=%b ack=%b, expected an=%b seg=%b dp=%b ack=%b",
                   cyc, bus.o_an, bus.o_seg, bus.o_dp, bus.o_load_ack, e.an, e.seg, e.dp, e.ack);
        end
      end
    end
  end

  initial begin
    bit          r;
    bit          ld;
    bit          ex;
    logic [15:0] d;

    // Reset held for two cycles
    step(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
    idle(20);

    // Basic load and scan order
    lz = 1'b0;
    load(16'h12AF, 4'h0);
    idle(100);

    // Extra tick two cycles into the blank interval
    for (int i = 0; i < 30 && tick_cnt != 2; i++) idle(1);
    step(1'b0, 1'b0, 16'h0000, 4'h0, 1'b1);
    idle(40);

    // Leading-zero suppression
    lz = 1'b1;
    load(16'h0007, 4'h0);
    idle(100);
    load(16'h0000, 4'h0);
    idle(100);
    load(16'h0000, 4'b0100);
    idle(100);
    lz = 1'b0;

    // Overwrite before the wrap: only the second value may appear
    load(16'h1111, 4'h0);
    idle(3);
    load(16'h2222, 4'h0);
    idle(60);

    // Load on the wrap edge while another value is pending
    load(16'h4444, 4'h0);
    for (int i = 0; i < 200 && !(m_idx == N - 1 && tick_cnt == 9); i++) idle(1);
    load(16'h5555, 4'h3);
    idle(90);

    // Reset while digit 2 is lit and a load is pending
    load(16'h6789, 4'h0);
    idle(60);
    for (int i = 0; i < 200 && !(m_idx == 2 && m_dark == 0 && tick_cnt < 8); i++) idle(1);
    load(16'h9999, 4'h0);
    step(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
    idle(80);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      ld = ($urandom_range(0, 15) == 0);
      ex = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) lz = ~lz;
      d  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step(r, ld, d, 4'($urandom_range(0, 3) == 0 ? $urandom : 0), ex);
    end
    idle(5);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
